axi_cmd_arbiter: RTL

- Shares the single AXI-lite master command port (start_write/start_read, addr, data, wstrb, psel) between two requesters: requester 0 is the core's LSU control-register path, requester 1 is a UART DMA/test engine.
- Grants round-robin, latches the winning command, and issues it as a one-cycle start pulse.
- Waits for the master's completion, or times out, then returns read data and status to the owner.
- Sits between the core-side control registers and the AXI-lite master that feeds the AXI-to-APB bridge and UART.

---
 rtl/axi_cmd_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: round-robin sharing of the single AXI-lite master command
// port between the LSU control-register path (requester 0) and the UART
// DMA/test engine (requester 1). A granted command is latched, issued as a
// one-cycle start pulse, then completed by m_done or aborted by a timeout.
module axi_cmd_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic [1:0]            req_i,
   input  logic [1:0]            we_i,
   input  logic [2*ADDR_W-1:0]   addr_i,
   input  logic [2*DATA_W-1:0]   wdata_i,
   input  logic [7:0]            wstrb_i,
   input  logic [1:0]            psel_i,
   output logic [1:0]            ack_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic [1:0]            resp_o,
   output logic                  m_start_write,
   output logic                  m_start_read,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_psel,
   input  logic                  m_done,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_slverr,
   output logic                  busy_o,
   output logic                  owner_o,
   output logic [7:0]            timeout_cnt_o
);

   // Timer value on which WAIT gives up; WAIT therefore lasts TIMEOUT_CYCLES cycles.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] RESP_OK      = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b01;
   localparam logic [1:0] RESP_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                ptr;
   logic                lat_we;
   logic [15:0]         timer;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          resp_q;

   logic                any_req;
   logic                grant;
   logic                win_we;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;
   logic [3:0]          win_wstrb;
   logic                win_psel;

   logic                take_grant;
   logic                expired;
   logic                done_hit;
   logic                tmo_hit;

   // Pick the winner: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      any_req = |req_i;
      grant   = 1'b0;
      if (req_i == 2'b11) begin
         grant = ptr;
      end else begin
         grant = req_i[1];
      end
      win_we    = grant ? we_i[1]                     : we_i[0];
      win_addr  = grant ? addr_i[2*ADDR_W-1:ADDR_W]   : addr_i[ADDR_W-1:0];
      win_wdata = grant ? wdata_i[2*DATA_W-1:DATA_W]  : wdata_i[DATA_W-1:0];
      win_wstrb = grant ? wstrb_i[7:4]                : wstrb_i[3:0];
      win_psel  = grant ? psel_i[1]                   : psel_i[0];
   end

   // Qualified events; m_done outside WAIT is dropped here, which also
   // discards a late completion arriving after a timeout.
   always_comb begin
      take_grant = (state == S_IDLE) && any_req;
      expired    = (timer == TMO_LAST);
      done_hit   = (state == S_WAIT) && m_done;
      tmo_hit    = (state == S_WAIT) && !m_done && expired;
   end

   // State register.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-state outputs; m_done takes priority over expiry.
   always_comb begin
      state_nxt     = state;
      m_start_write = 1'b0;
      m_start_read  = 1'b0;
      ack_o         = '0;
      rdata_o       = '0;
      resp_o        = '0;
      busy_o        = 1'b1;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (any_req) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            m_start_write = lat_we;
            m_start_read  = !lat_we;
            state_nxt     = S_WAIT;
         end
         S_WAIT: begin
            if (m_done || expired) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            ack_o     = owner_o ? 2'b10 : 2'b01;
            rdata_o   = rdata_q;
            resp_o    = resp_q;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Command latch: sampled only in the grant cycle, held through RESP.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         owner_o <= 1'b0;
         lat_we  <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_wstrb <= '0;
         m_psel  <= 1'b0;
      end else if (take_grant) begin
         owner_o <= grant;
         lat_we  <= win_we;
         m_addr  <= win_addr;
         m_wdata <= win_wdata;
         m_wstrb <= win_we ? win_wstrb : 4'b0000;
         m_psel  <= win_psel;
      end
   end

   // WAIT timer: cleared while issuing, counts every WAIT cycle.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         timer <= '0;
      end else if (state == S_ISSUE) begin
         timer <= '0;
      end else if (state == S_WAIT) begin
         timer <= timer + 16'd1;
      end
   end

   // Capture read data and status at completion or timeout.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rdata_q <= '0;
         resp_q  <= RESP_OK;
      end else if (done_hit) begin
         rdata_q <= lat_we ? '0 : m_rdata;
         resp_q  <= m_slverr ? RESP_SLVERR : RESP_OK;
      end else if (tmo_hit) begin
         rdata_q <= '0;
         resp_q  <= RESP_TIMEOUT;
      end
   end

   // Saturating count of aborted transactions.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         timeout_cnt_o <= '0;
      end else if (tmo_hit && (timeout_cnt_o != 8'hFF)) begin
         timeout_cnt_o <= timeout_cnt_o + 8'd1;
      end
   end

   // Round-robin pointer hands the next tie to the other requester.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ptr <= 1'b0;
      end else if (state == S_RESP) begin
         ptr <= ~owner_o;
      end
   end

endmodule
